fetch_unit: RTL and testbench

- Front-end producer for the Tomasulo core's instruction queue.
- Holds the architectural fetch PC and issues one instruction read at a time to instruction memory.
- Pushes each returned word and its PC into the instruction queue's write port; stalls while the queue is full.
- On a branch-misprediction redirect, retargets the PC and squashes any fetch still in flight.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory read, skid buffer toward the
// instruction queue, redirect squash. Optional JAL prediction via FETCH_JAL_PREDICT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        iq_we_o,
    output logic [31:0] iq_inst_o,
    output logic [31:0] iq_pc_o,
    input  logic        iq_full_i
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   hold_inst_q, hold_inst_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic [XLEN-1:0]   fetch_next_pc;

    // Successor of the instruction currently returning from memory.
`ifdef FETCH_JAL_PREDICT_EN
    logic            is_jal;
    logic [XLEN-1:0] jal_imm;
    assign is_jal  = (mem_rdata_i[6:0] == 7'b1101111);
    assign jal_imm = {{11{mem_rdata_i[31]}}, mem_rdata_i[31], mem_rdata_i[19:12],
                      mem_rdata_i[20], mem_rdata_i[30:21], 1'b0};
    assign fetch_next_pc = is_jal ? (req_pc_q + jal_imm) : (req_pc_q + XLEN'(4));
`else
    assign fetch_next_pc = req_pc_q + XLEN'(4);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        iq_we_o     = 1'b0;
        iq_inst_o   = '0;
        iq_pc_o     = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_q;
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    if (mem_gnt_i) state_d = S_DISCARD;
                end else if (mem_gnt_i) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = mem_rvalid_i ? S_REQ : S_DISCARD;
                end else if (mem_rvalid_i) begin
                    pc_d = fetch_next_pc;
                    if (iq_full_i) begin
                        hold_inst_d = mem_rdata_i;
                        hold_pc_d   = req_pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        iq_we_o   = 1'b1;
                        iq_inst_o = mem_rdata_i;
                        iq_pc_o   = req_pc_q;
                        state_d   = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                iq_inst_o = hold_inst_q;
                iq_pc_o   = hold_pc_q;
                if (redirect_i) begin
                    pc_d        = redirect_pc_i;
                    hold_inst_d = '0;
                    hold_pc_d   = '0;
                    state_d     = S_REQ;
                end else if (!iq_full_i) begin
                    iq_we_o = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                // Orphaned response of a squashed fetch is swallowed here.
                if (redirect_i) pc_d = redirect_pc_i;
                if (mem_rvalid_i) state_d = S_REQ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a one-outstanding memory model with metered grants,
// expected queue writes pushed by stimulus and popped by a negedge monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        iq_we_o;
    logic [31:0] iq_inst_o;
    logic [31:0] iq_pc_o;
    logic        iq_full_i = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    iq_entry_t   sb[$];
    int          checks = 0;
    int          errors = 0;
    int          gnt_allowed = 0;
    int          gnt_count;
    int          resp_cnt;
    int          lat = 1;
    int          cyc;
    logic [31:0] resp_addr;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .iq_we_o      (iq_we_o),
        .iq_inst_o    (iq_inst_o),
        .iq_pc_o      (iq_pc_o),
        .iq_full_i    (iq_full_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h0100_006F;
        return {a[25:2], 8'h13};
    endfunction

    // Memory model: grants only while the bench has granted budget left.
    assign mem_gnt_i    = mem_req_o && (gnt_count < gnt_allowed);
    assign mem_rvalid_i = (resp_cnt == 1);
    assign mem_rdata_i  = mem_rvalid_i ? mem_word(resp_addr) : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_cnt  <= 0;
            gnt_count <= 0;
            resp_addr <= '0;
            cyc       <= 0;
        end else begin
            cyc <= cyc + 1;
            if (mem_req_o && mem_gnt_i) begin
                resp_cnt  <= lat;
                resp_addr <= mem_addr_o;
                gnt_count <= gnt_count + 1;
            end else if (resp_cnt != 0) begin
                resp_cnt <= resp_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [31:0] pc);
        iq_entry_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every queue write.
    initial begin
        int wn = 0;
        iq_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (iq_full_i || redirect_i)
                    chk("we_while_full_or_redirect", 32'(iq_we_o), 32'd0);
                if (iq_we_o) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: pc %h inst %h, expected no write",
                                 iq_pc_o, iq_inst_o);
                    end else begin
                        e = sb.pop_front();
                        chk("iq_pc", iq_pc_o, e.pc);
                        chk("iq_inst", iq_inst_o, e.inst);
                    end
                    if (wn < 3) chk("write_cycle", 32'(cyc + 1), 32'(3 + 2 * wn));
                    wn++;
                end
            end
        end
    end

    task automatic wait_quiet(input string name, input logic [31:0] exp_addr);
        int n = 0;
        @(negedge clk);
        while (!(gnt_count == gnt_allowed && resp_cnt == 0 && sb.size() == 0 && mem_req_o)
               && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pending %0d, expected 0", name, sb.size());
        end
        chk(name, mem_addr_o, exp_addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_in_req(input logic [31:0] target);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        step();
        redirect_i    = 1'b0;
    endtask

    initial begin
        logic [31:0] jal_target;
`ifdef FETCH_JAL_PREDICT_EN
        jal_target = 32'h0000_0210;
`else
        jal_target = 32'h0000_0204;
`endif
        // Reset values
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_iq_we", 32'(iq_we_o), 32'd0);
        chk("rst_iq_pc", iq_pc_o, 32'd0);
        chk("rst_iq_inst", iq_inst_o, 32'd0);
        step();
        rst = 1'b0;

        // Streaming from RESET_PC with a zero-wait memory
        expect_write(32'h100);
        expect_write(32'h104);
        expect_write(32'h108);
        gnt_allowed = 3;
        @(negedge clk);
        chk("idle_no_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(mem_req_o), 32'd1);
        chk("first_addr", mem_addr_o, 32'h100);
        wait_quiet("addr_after_stream", 32'h10C);

        // Queue full while the response arrives: park in HOLD, write once
        step();
        iq_full_i = 1'b1;
        expect_write(32'h10C);
        gnt_allowed++;
        repeat (5) step();
        iq_full_i = 1'b0;
        wait_quiet("addr_after_hold", 32'h110);

        // Redirect in WAIT, response two cycles after grant is an orphan
        step();
        lat = 2;
        gnt_allowed++;
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("discard_no_req", 32'(mem_req_o), 32'd0);
        wait_quiet("addr_after_wait_redirect", 32'h400);
        lat = 1;
        step();
        expect_write(32'h400);
        gnt_allowed++;
        wait_quiet("addr_after_400", 32'h404);

        // Redirect coincident with rvalid: dropped, request next at target
        step();
        gnt_allowed++;
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h800;
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("rvalid_redirect_req", 32'(mem_req_o), 32'd1);
        chk("rvalid_redirect_addr", mem_addr_o, 32'h800);

        // Redirect in REQ without and with a grant
        redirect_in_req(32'hA00);
        @(negedge clk);
        chk("req_redirect_addr", mem_addr_o, 32'hA00);
        step();
        gnt_allowed++;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hB00;
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("req_gnt_redirect_discard", 32'(mem_req_o), 32'd0);
        wait_quiet("addr_after_req_gnt_redirect", 32'hB00);

        // PC wrap-around
        redirect_in_req(32'hFFFF_FFFC);
        expect_write(32'hFFFF_FFFC);
        gnt_allowed++;
        wait_quiet("addr_after_wrap", 32'h0);

        // JAL at 0x200
        redirect_in_req(32'h200);
        expect_write(32'h200);
        gnt_allowed++;
        wait_quiet("addr_after_jal", jal_target);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
